// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the matrix scanner
// and its consumer (keypad pins on one side, PIN logic on the other).
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );

    modport slave (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce; one key_valid pulse
// per physical press, codes BCD 0-9, 'A' for '*', 'B' for '#'.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic            clk,
    input  logic            rst_n,
    keypad_scanner_if.slave kp
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        HELD     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q;
    logic [3:0]    row_s_q;
    logic [1:0]    col_q, col_d;
    logic [3:0]    col_out_q, col_out_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;

    logic [1:0]    map_row;
    logic [3:0]    map_code;
    logic          map_ign;

    // Two-flop synchronizer; rows idle high, so flops clear to all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            row_s_q <= 4'hF;
        end else begin
            sync1_q <= kp.row_in;
            row_s_q <= sync1_q;
        end
    end

    // Lowest-index low row wins; row/column then index the keymap.
    always_comb begin
        map_row = 2'd3;
        if (!pat_q[0]) begin
            map_row = 2'd0;
        end else if (!pat_q[1]) begin
            map_row = 2'd1;
        end else if (!pat_q[2]) begin
            map_row = 2'd2;
        end
        map_ign  = 1'b0;
        map_code = 4'h0;
        unique case ({map_row, col_q})
            4'h0:    map_code = 4'h1;
            4'h1:    map_code = 4'h2;
            4'h2:    map_code = 4'h3;
            4'h4:    map_code = 4'h4;
            4'h5:    map_code = 4'h5;
            4'h6:    map_code = 4'h6;
            4'h8:    map_code = 4'h7;
            4'h9:    map_code = 4'h8;
            4'hA:    map_code = 4'h9;
            4'hC:    map_code = 4'hA;
            4'hD:    map_code = 4'h0;
            4'hE:    map_code = 4'hB;
            default: map_ign  = 1'b1;
        endcase
    end

    // Scan / debounce / report / wait-for-release sequencing.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        scan_d  = scan_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        unique case (state_q)
            SCAN: begin
                if (scan_q == SCAN_LAST) begin
                    scan_d = '0;
                    if (row_s_q != 4'hF) begin
                        pat_d   = row_s_q;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s_q != pat_q) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    scan_d  = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!map_ign) begin
                    code_d  = map_code;
                    valid_d = 1'b1;
                end
                held_d  = 1'b1;
                cnt_d   = '0;
                state_d = HELD;
            end
            HELD: begin
                if (row_s_q != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    held_d  = 1'b0;
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    scan_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    assign col_out_d = ~(4'b0001 << col_d);

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            col_q     <= 2'd0;
            col_out_q <= 4'b1110;
            scan_q    <= '0;
            cnt_q     <= '0;
            pat_q     <= 4'hF;
            code_q    <= 4'h0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            col_out_q <= col_out_d;
            scan_q    <= scan_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

    assign kp.col_out   = col_out_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a physical keypad model drives
// the rows, and a reference model is compared every cycle.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DC = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV    (SD),
        .DEBOUNCE_CNT(DC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kp.slave)
    );

    always #5 clk = ~clk;

    // pressed[r*4+c]: key at row r / column c is physically down
    logic [15:0] pressed = '0;
    logic [3:0]  rows_v;

    always_comb begin
        rows_v = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col_out[c])
                    rows_v[r] = 1'b0;
    end
    assign kp.row_in = rows_v;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---- reference model (slot-time based) ----
    // -1 marks keys A-D, which are tracked but never reported
    int keymap [16] = '{1, 2, 3, -1, 4, 5, 6, -1,
                        7, 8, 9, -1, 10, 0, 11, -1};
    int         m_ph;      // 0 scanning, 1 qualifying, 3 report, 2 holding
    int         m_tick;    // position in the 4-column scan, 0..4*SD-1
    int         m_run;
    int         m_lockcol;
    logic [3:0] m_s1, m_rs, m_pat, m_code;
    logic       m_valid, m_held;
    logic [3:0] seen [$];

    function automatic int low_row(input logic [3:0] p);
        for (int i = 0; i < 4; i++)
            if (!p[i]) return i;
        return 3;
    endfunction

    function automatic logic [3:0] m_col_out();
        logic [3:0] one;
        int c;
        one = 4'b0001;
        c = (m_ph == 0) ? (m_tick / SD) % 4 : m_lockcol;
        return ~(one << c);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_tick = 0; m_run = 0; m_lockcol = 0;
        m_s1 = 4'hF; m_rs = 4'hF; m_pat = 4'hF;
        m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] rin);
        int k;
        m_valid = 1'b0;
        case (m_ph)
            0: begin
                if ((m_tick % SD) == SD - 1 && m_rs != 4'hF) begin
                    m_ph = 1; m_pat = m_rs; m_run = 0;
                    m_lockcol = (m_tick / SD) % 4;
                end else begin
                    m_tick = (m_tick + 1) % (4 * SD);
                end
            end
            1: begin
                if (m_rs == m_pat) begin
                    m_run++;
                    if (m_run == DC) m_ph = 3;
                end else begin
                    m_ph = 0;
                    m_tick = ((m_lockcol + 1) % 4) * SD;
                end
            end
            3: begin
                k = keymap[low_row(m_pat) * 4 + m_lockcol];
                if (k >= 0) begin
                    m_code = k[3:0];
                    m_valid = 1'b1;
                end
                m_held = 1'b1; m_run = 0; m_ph = 2;
            end
            default: begin
                if (m_rs == 4'hF) begin
                    m_run++;
                    if (m_run == DC) begin
                        m_held = 1'b0; m_ph = 0;
                        m_tick = ((m_lockcol + 1) % 4) * SD;
                    end
                end else begin
                    m_run = 0;
                end
            end
        endcase
        m_rs = m_s1;
        m_s1 = rin;
    endtask

    // Per-cycle compare of all outputs against the model.
    initial begin
        logic [9:0] got, want;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(kp.row_in);
            #1;
            got  = {kp.col_out, kp.key_code, kp.key_valid, kp.key_held};
            want = {m_col_out(), m_code, m_valid, m_held};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cycle t=%0t: col/code/valid/held got %b/%h/%b/%b required %b/%h/%b/%b",
                         $time, got[9:6], got[5:2], got[1], got[0],
                         want[9:6], want[5:2], want[1], want[0]);
            end
            if (kp.key_valid) seen.push_back(kp.key_code);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input int r, input int c, input logic down);
        pressed[r*4+c] = down;
    endtask

    logic [3:0] exp_codes [7] = '{4'h5, 4'hA, 4'hB, 4'h3, 4'h4, 4'h8, 4'h8};

    initial begin
        int n0;
        int t;
        cycles(3);
        check("reset col_out", kp.col_out, 4'b1110);
        check("reset key_code", kp.key_code, 4'h0);
        check("reset key_valid", kp.key_valid, 1'b0);
        check("reset key_held", kp.key_held, 1'b0);
        rst_n = 1'b1;

        // key 5: single pulse, frozen column, release latency
        key(1, 1, 1'b1);
        cycles(50);
        check("key5 col frozen", kp.col_out, 4'b1101);
        check("key5 held", kp.key_held, 1'b1);
        cycles(50);
        check("key5 col frozen late", kp.col_out, 4'b1101);
        key(1, 1, 1'b0);
        t = 0;
        while (kp.key_held && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("key5 release edges", t, 10);
        check("key5 pulse count", seen.size(), 1);
        cycles(20);

        // '*' then '#'
        key(3, 0, 1'b1); cycles(60); key(3, 0, 1'b0); cycles(30);
        key(3, 2, 1'b1); cycles(60); key(3, 2, 1'b0); cycles(30);
        check("star/hash pulse count", seen.size(), 3);

        // bouncing key 3, then stable
        n0 = seen.size();
        for (int i = 0; i < 40; i++) begin
            pressed[2] = (i % 4) != 3;
            cycles(1);
        end
        check("bounce no pulse", seen.size(), n0);
        key(0, 2, 1'b1); cycles(60); key(0, 2, 1'b0); cycles(30);
        check("bounce single pulse", seen.size(), n0 + 1);

        // ignored key A
        n0 = seen.size();
        key(0, 3, 1'b1); cycles(40);
        check("keyA held", kp.key_held, 1'b1);
        check("keyA no valid", kp.key_valid, 1'b0);
        key(0, 3, 1'b0); cycles(30);
        check("keyA no pulse", seen.size(), n0);
        check("keyA code kept", kp.key_code, 4'h3);

        // keys 7 and 4 together, then 9 while held
        n0 = seen.size();
        key(2, 0, 1'b1); key(1, 0, 1'b1); cycles(50);
        key(2, 2, 1'b1); cycles(30);
        check("7+4 held", kp.key_held, 1'b1);
        pressed = '0; cycles(30);
        check("7+4 pulse count", seen.size(), n0 + 1);

        // reset during HELD with key 8 still down
        n0 = seen.size();
        key(2, 1, 1'b1); cycles(50);
        check("key8 held pre-reset", kp.key_held, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid reset col_out", kp.col_out, 4'b1110);
        check("mid reset key_held", kp.key_held, 1'b0);
        check("mid reset key_code", kp.key_code, 4'h0);
        cycles(1);
        rst_n = 1'b1;
        cycles(60); key(2, 1, 1'b0); cycles(30);
        check("key8 pulse count", seen.size(), n0 + 2);

        check("total pulses", seen.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < seen.size())
                check($sformatf("pulse %0d code", i), seen[i], exp_codes[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
